// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle RV32I sequencer (fetch, decode, execute, write back) driving the ALU
// Optional feature macro: CONTROL_ILLEGAL_TRAP_EN (illegal instruction enters a sticky TRAP state;
// when undefined, illegal instructions retire as NOPs and trap is tied low).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   imem_req, imem_addr           fetch request (held until accepted) and address (= pc)
//   imem_valid, imem_rdata        fetch response, accepted in the cycle it is seen during FETCH
//   rs1_addr, rs2_addr, rd_addr   register-file read/write addresses (registered)
//   ALU_func, imm                 ALU operation and immediate (registered)
//   alu_result                    ALU output, used for write-back data and branch resolution
//   rd_wdata, rf_we               register-file write data and one-cycle write strobe
//   pc, retire, trap              program counter, retire pulse, sticky illegal-instruction flag

package TypesPkg;
    typedef enum logic [4:0] {
        ADD, SUB, SLL, SLT, XOR, SRL, SRA, OR, AND,
        ADDI, SLTI, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        EQL, LT, GE
    } ALU_func_t;
endpackage

module control_unit
    import TypesPkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output ALU_func_t   ALU_func,
    output logic [31:0] imm,
    input  logic [31:0] alu_result,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_wdata,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic        retire,
    output logic        trap
);
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

`ifdef CONTROL_ILLEGAL_TRAP_EN
    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, TRAP} state_t;
`else
    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK} state_t;
`endif

    state_t      state, next_state;
    logic [31:0] instr;
    logic        is_branch;
    logic        dec_legal, dec_branch;
    ALU_func_t   dec_func;
    logic [31:0] dec_imm;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        branch_taken;

    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    // BNE shares the EQL comparison with BEQ, so its sense is flipped here.
    assign branch_taken = alu_result[0] ^ (funct3 == 3'b001);

    // rst gating keeps the request low for the whole reset window even though
    // the state register already sits in FETCH.
    assign imem_req  = (state == FETCH) && !rst;
    assign imem_addr = pc;

`ifdef CONTROL_ILLEGAL_TRAP_EN
    assign trap = (state == TRAP);
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        dec_legal  = 1'b0;
        dec_branch = 1'b0;
        dec_func   = ADD;
        dec_imm    = 32'd0;
        case (instr[6:0])
            OP_R: begin
                dec_legal = (funct7 == F7_ZERO);
                case (funct3)
                    3'b000: begin
                        if (funct7 == F7_ALT) begin
                            dec_func  = SUB;
                            dec_legal = 1'b1;
                        end else begin
                            dec_func = ADD;
                        end
                    end
                    3'b001: dec_func = SLL;
                    3'b010: dec_func = SLT;
                    3'b100: dec_func = XOR;
                    3'b101: begin
                        if (funct7 == F7_ALT) begin
                            dec_func  = SRA;
                            dec_legal = 1'b1;
                        end else begin
                            dec_func = SRL;
                        end
                    end
                    3'b110: dec_func = OR;
                    3'b111: dec_func = AND;
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_I: begin
                dec_legal = 1'b1;
                dec_imm   = {{20{instr[31]}}, instr[31:20]};
                case (funct3)
                    3'b000: dec_func = ADDI;
                    3'b010: dec_func = SLTI;
                    3'b100: dec_func = XORI;
                    3'b110: dec_func = ORI;
                    3'b111: dec_func = ANDI;
                    // Shift amount only: the funct7 field must not leak into the ALU operand.
                    3'b001: begin
                        dec_func  = SLLI;
                        dec_imm   = {27'd0, instr[24:20]};
                        dec_legal = (funct7 == F7_ZERO);
                    end
                    3'b101: begin
                        dec_imm   = {27'd0, instr[24:20]};
                        dec_legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                        if (funct7 == F7_ALT) begin
                            dec_func = SRAI;
                        end else begin
                            dec_func = SRLI;
                        end
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_B: begin
                dec_legal  = 1'b1;
                dec_branch = 1'b1;
                dec_imm    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                case (funct3)
                    3'b000, 3'b001: dec_func = EQL;
                    3'b100:         dec_func = LT;
                    3'b101:         dec_func = GE;
                    default:        dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        retire     = 1'b0;
        rf_we      = 1'b0;
        case (state)
            FETCH: begin
                if (imem_valid) next_state = DECODE;
            end
            DECODE: begin
                if (dec_legal) begin
                    next_state = EXECUTE;
                end else begin
`ifdef CONTROL_ILLEGAL_TRAP_EN
                    next_state = TRAP;
`else
                    retire     = 1'b1;
                    next_state = FETCH;
`endif
                end
            end
            EXECUTE: begin
                if (is_branch) begin
                    retire     = 1'b1;
                    next_state = FETCH;
                end else begin
                    next_state = WRITEBACK;
                end
            end
            WRITEBACK: begin
                rf_we      = (rd_addr != 5'd0);
                retire     = 1'b1;
                next_state = FETCH;
            end
`ifdef CONTROL_ILLEGAL_TRAP_EN
            TRAP: next_state = TRAP;
`endif
            default: next_state = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            instr     <= 32'd0;
            rs1_addr  <= 5'd0;
            rs2_addr  <= 5'd0;
            rd_addr   <= 5'd0;
            ALU_func  <= ADD;
            imm       <= 32'd0;
            rd_wdata  <= 32'd0;
            is_branch <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                FETCH: begin
                    if (imem_valid) begin
                        instr    <= imem_rdata;
                        rs1_addr <= imem_rdata[19:15];
                        rs2_addr <= imem_rdata[24:20];
                        rd_addr  <= imem_rdata[11:7];
                    end
                end
                DECODE: begin
                    if (dec_legal) begin
                        ALU_func  <= dec_func;
                        imm       <= dec_imm;
                        is_branch <= dec_branch;
                    end
`ifndef CONTROL_ILLEGAL_TRAP_EN
                    else begin
                        pc <= pc + 32'd4;
                    end
`endif
                end
                EXECUTE: begin
                    if (is_branch) begin
                        pc <= branch_taken ? (pc + imm) : (pc + 32'd4);
                    end else begin
                        rd_wdata <= alu_result;
                    end
                end
                WRITEBACK: pc <= pc + 32'd4;
                default: ;
            endcase
        end
    end

endmodule
